// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver: LSB-first frames of 1 start bit, DBIT data bits,
// optional parity and a SB_TICK-long stop period. Reports a completion pulse plus error flags.
module uart_rx_os #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err
);

    // The tick counter widens to 5 bits only when the stop period exceeds one bit time.
    localparam int             SW      = (SB_TICK > 16) ? 5 : 4;
    localparam logic [SW-1:0]  S_MID   = SW'(7);
    localparam logic [SW-1:0]  S_LAST  = SW'(15);
    localparam logic [SW-1:0]  S_STOP  = SW'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST  = 3'(DBIT - 1);
    localparam logic           PAR_ON  = (PARITY_EN != 0);
    localparam logic           PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          par_q, par_d;
    logic          perr_q, perr_d;
    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    logic          prev_q, prev_d;
    logic          done_q, done_d;
    logic [7:0]    dout_q, dout_d;
    logic          ferr_q, ferr_d;
    logic          perr_out_q, perr_out_d;
    logic          fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            prev_q     <= 1'b1;
            done_q     <= 1'b0;
            dout_q     <= '0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            prev_q     <= prev_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            ferr_q     <= ferr_d;
            perr_out_q <= perr_out_d;
        end
    end

    assign fall = prev_q & ~rxs_q;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        par_d      = par_q;
        perr_d     = perr_q;
        sync1_d    = rx;
        rxs_d      = sync1_q;
        prev_d     = rxs_q;
        done_d     = 1'b0;
        dout_d     = dout_q;
        ferr_d     = ferr_q;
        perr_out_d = perr_out_q;

        case (state_q)
            IDLE: begin
                // Only a high-to-low transition starts a frame, so a held-low line is ignored.
                if (fall) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rxs_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            b_d     = '0;
                            par_d   = 1'b0;
                            perr_d  = 1'b0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d      = '0;
                        b_d[n_q] = rxs_q;
                        par_d    = par_q ^ rxs_q;
                        if (n_q == N_LAST) begin
                            state_d = PAR_ON ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        perr_d  = par_q ^ rxs_q ^ PAR_ODD;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        dout_d     = b_q;
                        ferr_d     = ~rxs_q;
                        perr_out_d = PAR_ON & perr_q;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_out_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, even-parity and odd-parity receivers fed from one
// serial driver, checked every cycle against a frame-level expected queue.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       tick_en;
    logic       line;
    logic [1:0] sel;
    logic       rx0, rx1, rx2;
    logic [7:0] dout0, dout1, dout2;
    logic       done0, done1, done2;
    logic       ferr0, ferr1, ferr2;
    logic       perr0, perr1, perr2;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {dut id[1:0], frame_err, parity_err, dout[7:0]}
    logic [11:0] exp_q[$];
    logic [9:0]  last[3];
    int          pulses[3];

    // ---------------- clock / reset / tick ----------------
    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = tick_en;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    assign rx0 = (sel == 2'd0) ? line : 1'b1;
    assign rx1 = (sel == 2'd1) ? line : 1'b1;
    assign rx2 = (sel == 2'd2) ? line : 1'b1;

    uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx0),
        .dout(dout0), .rx_done_tick(done0), .frame_err(ferr0), .parity_err(perr0)
    );
    uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx1),
        .dout(dout1), .rx_done_tick(done1), .frame_err(ferr1), .parity_err(perr1)
    );
    uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx2),
        .dout(dout2), .rx_done_tick(done2), .frame_err(ferr2), .parity_err(perr2)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic mon(input int k, input logic dn, input logic [7:0] d,
                       input logic fe, input logic pe);
        logic [11:0] e;
        if (rst) last[k] = '0;
        if (dn) begin
            pulses[k]++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                if (n_fail <= 40)
                    $display("FAIL unexpected_pulse_dut%0d: got dout=%0h want no pulse", k, d);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("frame_dut%0d", k), {20'd0, 2'(k), fe, pe, d}, {20'd0, e});
                last[k] = e[9:0];
            end
        end else begin
            chk($sformatf("hold_dut%0d", k), {22'd0, fe, pe, d}, {22'd0, last[k]});
        end
    endtask

    always @(negedge clk) begin
        mon(0, done0, dout0, ferr0, perr0);
        mon(1, done1, dout1, ferr1, perr1);
        mon(2, done2, dout2, ferr2, perr2);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        int k = 0;
        int guard = 0;
        while (k < n) begin
            @(posedge clk);
            guard++;
            if (s_tick) k++;
            if (guard > 2000) begin
                fail_now("tick_wait");
                return;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input int nt);
        line = v;
        wait_ticks(nt);
    endtask

    task automatic send_frame(input int k, input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic par_odd, input logic stop_v);
        logic perr_e;
        int   ones;
        sel  = 2'(k);
        ones = $countones(data) + int'(par_bit);
        perr_e = par_en ? (((ones % 2) == 1) != par_odd) : 1'b0;
        exp_q.push_back({2'(k), ~stop_v, perr_e, data});
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(data[i], 16);
        if (par_en) drive(par_bit, 16);
        drive(stop_v, 16);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            last[i]   = '0;
            pulses[i] = 0;
        end
        rst = 1'b1; line = 1'b1; sel = 2'd0; tick_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_dout0", {24'd0, dout0}, 32'h0);
        chk("reset_flags0", {29'd0, done0, ferr0, perr0}, 32'h0);
        chk("reset_dout1", {24'd0, dout1}, 32'h0);
        #1;
        drive(1'b1, 32);

        // 8N1 basic frame
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t1_dout", {24'd0, dout0}, 32'hA5);
        chk("t1_flags", {30'd0, ferr0, perr0}, 32'h0);
        chk("t1_pulses", pulses[0], 1);

        // Short low glitch must be rejected
        drive(1'b0, 4);
        drive(1'b1, 48);
        chk("t2_no_pulse", pulses[0], 1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t2_dout", {24'd0, dout0}, 32'h3C);

        // Framing error followed by a held-low line
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 48);
        drain();
        chk("t3_dout", {24'd0, dout0}, 32'h55);
        chk("t3_ferr", {31'd0, ferr0}, 32'h1);
        chk("t3_pulses", pulses[0], 3);
        drive(1'b1, 32);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t3_next_dout", {24'd0, dout0}, 32'h12);
        chk("t3_next_ferr", {31'd0, ferr0}, 32'h0);

        // Parity: even then odd receivers
        drive(1'b1, 16);
        send_frame(1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t4_even_ok", {31'd0, perr1}, 32'h0);
        send_frame(1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        chk("t4_even_bad", {31'd0, perr1}, 32'h1);
        send_frame(2, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        chk("t4_odd_bad", {31'd0, perr2}, 32'h1);
        send_frame(2, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1);
        drain();
        chk("t4_odd_ok", {31'd0, perr2}, 32'h0);
        chk("t4_dout2", {24'd0, dout2}, 32'h81);
        drive(1'b1, 16);

        // Back-to-back frames, no idle gap
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t5_dout", {24'd0, dout0}, 32'hFF);
        chk("t5_pulses", pulses[0], 6);

        // s_tick paused mid-frame: frame still received intact
        drive(1'b1, 16);
        fork
            begin
                repeat (200) @(posedge clk);
                #1 tick_en = 1'b0;
                repeat (70) @(posedge clk);
                #1 tick_en = 1'b1;
            end
        join_none
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("freeze_dout", {24'd0, dout0}, 32'h96);

        // Reset during data bit 3 aborts the frame
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b0, 8);
        rst = 1'b1;
        line = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_dout", {24'd0, dout0}, 32'h0);
        chk("t6_rst_flags", {29'd0, done0, ferr0, perr0}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 320);
        chk("t6_no_pulse", pulses[0], 7);
        chk("t6_dout_cleared", {24'd0, dout0}, 32'h0);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t6_next_dout", {24'd0, dout0}, 32'hC3);
        chk("t6_pulses", pulses[0], 8);

        drive(1'b1, 32);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
